vlsara_adder: RTL and testbench
===============================

Name: vlsara_adder

Overview:
- Variable-latency speculative adder: a registered, handshaked successor to the combinational group-speculative adder.
- Each group's carry-out is either speculated from the group's top-bit generate or computed exactly, selected per group at run time.
- An exact reference result is computed in parallel and any misspeculation is flagged.
- On error, a correction cycle returns the exact sum, unless approximate mode is requested.

Parameters:
- SIZE, 32, operand width in bits; must be a multiple of GROUP_SIZE.
- GROUP_SIZE, 4, bits per speculation group; NG = SIZE/GROUP_SIZE.
- CNT_W, 16, width of the error-statistics counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand-valid strobe
- in_ready  output  1  block can accept operands
- a  input  [SIZE:1]  operand A
- b  input  [SIZE:1]  operand B
- cin  input  1  carry-in
- select  input  [NG:1]  select[j]=1: group j carry-out computed exactly
- approx_mode  input  1  1: deliver speculative result even on error
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  [SIZE:1]  result sum
- cout  output  1  result carry-out
- spec_err  output  1  speculative result differed from exact for this op
- err_cnt  output  [CNT_W-1:0]  saturating count of ops with spec_err=1

Behaviour:
- Clock/reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, spec_err=0, err_cnt=0, operand registers cleared.
- FSM states: IDLE, EVAL, CORR, OUT.
- in_ready = (state==IDLE) | (state==OUT & out_ready).
- Accept: in_valid & in_ready at an edge latches a, b, cin, select and approx_mode; state goes to EVAL.
- Speculative carry chain (EVAL, combinational from latched operands):
  - c0 = cin.
  - Group j carry-out cj = select[j] ? full carry of group j given c(j-1) : a[j*GROUP_SIZE] & b[j*GROUP_SIZE].
  - Bits inside a group ripple from c(j-1); sum bit = p xor incoming carry; spec cout = cNG.
- Exact result = a + b + cin, SIZE+1 bits.
- err = ({spec cout, spec sum} != exact).
- EVAL transitions:
  - err=0, or err=1 with approx_mode=1: register the speculative result and err into sum/cout/spec_err; go to OUT. Latency is 2 edges from accept.
  - err=1 with approx_mode=0: go to CORR.
- CORR: register the exact result and spec_err=1; go to OUT. Latency is 3 edges.
- OUT: out_valid=1. sum, cout and spec_err are held stable until out_ready=1.
  - out_ready=1 with in_valid=1: accept the new op in the same edge, go to EVAL, out_valid deasserts.
  - out_ready=1 with in_valid=0: go to IDLE.
- err_cnt increments by 1 in the cycle spec_err is registered as 1. It saturates at all-ones and never wraps.
- Inputs are ignored outside accept edges. Changes on a, b or select after accept have no effect.
- Reset asserted mid-operation aborts the op: no out_valid is produced and all outputs return to reset values immediately.
- select all ones guarantees err=0.

Optional Feature:
- Macro: VLSARA_ERR_CNT_EN.
- Defined: err_cnt behaves as above.
- Undefined: no counter register is built, err_cnt is tied to 0, and all other behaviour is unchanged.

Test Plan:
- (1) Default params, select=0x00, a=0x0000000F, b=0x00000001, cin=0, approx_mode=0 -> out_valid 3 edges after accept, sum=0x00000010, cout=0, spec_err=1, err_cnt=1.
- (2) Same operands as (1) with approx_mode=1 -> out_valid 2 edges after accept, sum=0x00000000, spec_err=1.
- (3) select=0xFF, a=0xFFFFFFFF, b=0x00000000, cin=1 -> 2-edge latency, sum=0x00000000, cout=1, spec_err=0, err_cnt unchanged.
- (4) select=0x00, a=0x12345678, b=0x11111111, cin=0 -> 2-edge latency, sum=0x23456789, cout=0, spec_err=0.
- (5) Back-pressure: hold out_ready=0 for 5 cycles in OUT -> out_valid, sum and spec_err stable, in_ready=0. Then out_ready=1 with in_valid=1 -> new op accepted on that edge, out_valid=0 next cycle.
- (6) Assert rst_n=0 during CORR -> outputs reset asynchronously, no out_valid. With CNT_W=2 and the macro defined, 5 consecutive error ops -> err_cnt saturates at 3. With the macro undefined -> err_cnt stays 0.

Source files
------------

// File: rtl/vlsara_adder.sv
// vlsara_adder: registered variable-latency speculative adder with exact-result correction.
// Optional saturating misspeculation counter is built when VLSARA_ERR_CNT_EN is defined.
module vlsara_adder #(
    parameter int SIZE       = 32,
    parameter int GROUP_SIZE = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SIZE:1]     a,
    input  logic [SIZE:1]     b,
    input  logic              cin,
    input  logic [SIZE/GROUP_SIZE:1] select,
    input  logic              approx_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SIZE:1]     sum,
    output logic              cout,
    output logic              spec_err,
    output logic [CNT_W-1:0]  err_cnt
);
    localparam int NG = SIZE / GROUP_SIZE;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EVAL = 2'd1;
    localparam logic [1:0] CORR = 2'd2;
    localparam logic [1:0] OUT  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [SIZE:1] a_q, a_d, b_q, b_d, sum_q, sum_d, spec_sum;
    logic [NG:1]   sel_q, sel_d;
    logic          cin_q, cin_d, approx_q, approx_d, cout_q, cout_d, err_q, err_d;
    logic          spec_cout, c, cc, err, accept;
    logic [SIZE:0] exact;

    // Each group ripples internally; its carry-out is either the true ripple carry or a guess from the top bit.
    always_comb begin
        spec_sum = '0;
        c = cin_q;
        cc = 1'b0;
        for (int j = 1; j <= NG; j++) begin
            cc = c;
            for (int k = 1; k <= GROUP_SIZE; k++) begin
                spec_sum[(j-1)*GROUP_SIZE+k] = a_q[(j-1)*GROUP_SIZE+k] ^ b_q[(j-1)*GROUP_SIZE+k] ^ cc;
                cc = (a_q[(j-1)*GROUP_SIZE+k] & b_q[(j-1)*GROUP_SIZE+k]) |
                     ((a_q[(j-1)*GROUP_SIZE+k] ^ b_q[(j-1)*GROUP_SIZE+k]) & cc);
            end
            c = sel_q[j] ? cc : (a_q[j*GROUP_SIZE] & b_q[j*GROUP_SIZE]);
        end
        spec_cout = c;
    end

    assign exact     = {1'b0, a_q} + {1'b0, b_q} + {{SIZE{1'b0}}, cin_q};
    assign err       = {spec_cout, spec_sum} != exact;
    assign in_ready  = (state_q == IDLE) | ((state_q == OUT) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = state_q == OUT;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign spec_err  = err_q;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        sel_d    = sel_q;
        approx_d = approx_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        err_d    = err_q;
        case (state_q)
            EVAL: begin
                if (!err || approx_q) begin
                    sum_d   = spec_sum;
                    cout_d  = spec_cout;
                    err_d   = err;
                    state_d = OUT;
                end else begin
                    state_d = CORR;
                end
            end
            CORR: begin
                sum_d   = exact[SIZE-1:0];
                cout_d  = exact[SIZE];
                err_d   = 1'b1;
                state_d = OUT;
            end
            OUT:     state_d = out_ready ? IDLE : OUT;
            default: state_d = state_q;
        endcase
        if (accept) begin
            a_d      = a;
            b_d      = b;
            cin_d    = cin;
            sel_d    = select;
            approx_d = approx_mode;
            state_d  = EVAL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            sel_q    <= '0;
            approx_q <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            sel_q    <= sel_d;
            approx_q <= approx_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            err_q    <= err_d;
        end
    end

`ifdef VLSARA_ERR_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             set_err;
    // Counts each op whose registered spec_err is 1, at the edge it gets registered.
    assign set_err = ((state_q == EVAL) & err & approx_q) | (state_q == CORR);
    assign cnt_d   = (set_err && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign err_cnt = cnt_q;
`else
    assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_vlsara_adder.sv
// tb_vlsara_adder: directed self-checking bench for vlsara_adder using immediate assertions.
module tb_vlsara_adder;
    logic        clk, rst_n, in_valid, in_ready, cin, approx_mode, out_valid, out_ready, cout, spec_err;
    logic [32:1] a, b, sum;
    logic [8:1]  select;
    logic [1:0]  err_cnt;
    int          checks = 0;
    int          errors = 0;
    int          exp_cnt = 0;
`ifdef VLSARA_ERR_CNT_EN
    bit          cnt_on = 1'b1;
`else
    bit          cnt_on = 1'b0;
`endif

    vlsara_adder #(.SIZE(32), .GROUP_SIZE(4), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .select(select), .approx_mode(approx_mode),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
        .spec_err(spec_err), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bump();
        if (cnt_on && exp_cnt != 3) exp_cnt++;
    endtask

    task automatic go(input logic [32:1] ta, input logic [32:1] tb_, input logic tc,
                      input logic [8:1] ts, input logic tm);
        chk("in_ready_idle", in_ready, 1);
        a = ta; b = tb_; cin = tc; select = ts; approx_mode = tm; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; a = ~ta; b = ~tb_; cin = ~tc; select = ~ts; approx_mode = ~tm;
        chk("eval_out_valid", out_valid, 0);
        chk("eval_in_ready", in_ready, 0);
    endtask

    task automatic result(input string tag, input logic [32:1] es, input logic ec, input logic ee);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_err"}, spec_err, ee);
        chk({tag, "_cnt"}, err_cnt, exp_cnt);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("drain_valid", out_valid, 0);
        chk("drain_ready", in_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        select = '0; approx_mode = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_err", spec_err, 0);
        chk("rst_cnt", err_cnt, 0);
        #1 rst_n = 1'b1;

        // Misspeculation corrected: one extra cycle through CORR.
        go(32'h0000000F, 32'h00000001, 1'b0, 8'h00, 1'b0);
        tick();
        chk("corr_out_valid", out_valid, 0);
        tick();
        bump();
        result("t1", 32'h00000010, 1'b0, 1'b1);
        drain();

        go(32'h0000000F, 32'h00000001, 1'b0, 8'h00, 1'b1);
        tick();
        bump();
        result("t2", 32'h00000000, 1'b0, 1'b1);
        drain();

        go(32'hFFFFFFFF, 32'h00000000, 1'b1, 8'hFF, 1'b0);
        tick();
        result("t3", 32'h00000000, 1'b1, 1'b0);
        drain();

        go(32'h80000000, 32'h80000000, 1'b0, 8'h00, 1'b0);
        tick();
        result("topcarry", 32'h00000000, 1'b1, 1'b0);
        drain();

        go(32'h12345678, 32'h11111111, 1'b0, 8'h00, 1'b0);
        tick();
        result("t4", 32'h23456789, 1'b0, 1'b0);
        drain();

        // Back-pressure, then accept a new op on the releasing edge.
        go(32'h0000000F, 32'h00000001, 1'b0, 8'h00, 1'b1);
        tick();
        bump();
        for (int i = 0; i < 5; i++) begin
            tick();
            result("hold", 32'h00000000, 1'b0, 1'b1);
            chk("hold_in_ready", in_ready, 0);
        end
        a = 32'h12345678; b = 32'h11111111; cin = 1'b0; select = 8'h00; approx_mode = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        #1 chk("release_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        chk("t5_out_valid_low", out_valid, 0);
        chk("t5_in_ready_low", in_ready, 0);
        tick();
        result("t5", 32'h23456789, 1'b0, 1'b0);
        drain();

        // Asynchronous reset during CORR aborts the op.
        go(32'h0000000F, 32'h00000001, 1'b0, 8'h00, 1'b0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_sum", sum, 0);
        chk("arst_err", spec_err, 0);
        chk("arst_cnt", err_cnt, 0);
        rst_n = 1'b1;
        tick();
        chk("arst_no_valid", out_valid, 0);
        tick();
        chk("arst_no_valid2", out_valid, 0);

        for (int i = 0; i < 5; i++) begin
            go(32'h000000FF, 32'h00000001, 1'b0, 8'h00, 1'b0);
            tick();
            tick();
            bump();
            result("sat", 32'h00000100, 1'b0, 1'b1);
            drain();
        end
        chk("sat_final", err_cnt, cnt_on ? 3 : 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
